// File: rtl/id_stage.sv
// RV32I decode/issue stage: accepts one instruction from fetch, decodes it into a
// micro-program entry address plus operand fields, issues it, and holds until done.
module id_stage #(
  parameter int COLS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_id_valid_inst,
  input  logic [COLS-1:0] if_id_instr,
  input  logic [COLS-1:0] if_id_pc,
  output logic            id_ready,
  input  logic            done,
  output logic [4:0]      decode_addr,
  output logic            id_rf_valid_inst,
  output logic [4:0]      rd_index,
  output logic [4:0]      rs1_index,
  output logic [4:0]      rs2_index,
  output logic [COLS-1:0] immediate,
  output logic [COLS-1:0] pc_reg,
  output logic [COLS-1:0] pc_plus4,
  output logic [1:0]      id_rf_shift_controls,
  output logic            illegal_inst
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  state_e state_q, state_d;
  logic   accept;

  logic [31:0] w;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  logic               legal_d;
  logic [4:0]         addr_d;
  logic signed [31:0] imm_d;
  logic [1:0]         shift_d;

  logic [4:0]      decode_addr_q, rd_q, rs1_q, rs2_q;
  logic [COLS-1:0] immediate_q, pc_q, pc_plus4_q;
  logic [1:0]      shift_q;
  logic            valid_q, illegal_q;

  assign w      = if_id_instr[31:0];
  assign opcode = w[6:0];
  assign funct3 = w[14:12];
  assign funct7 = w[31:25];

  assign imm_i  = {{20{w[31]}}, w[31:20]};
  assign imm_s  = {{20{w[31]}}, w[31:25], w[11:7]};
  assign imm_b  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  assign imm_u  = {w[31:12], 12'b0};
  assign imm_j  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  assign imm_sh = {27'b0, w[24:20]};

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    legal_d = 1'b0;
    addr_d  = 5'd0;
    imm_d   = '0;
    shift_d = 2'b00;
    unique case (opcode)
      OP_R: begin
        legal_d = (funct7 == 7'b0) ||
                  (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
        case (funct3)
          3'b000:  addr_d = (funct7 == F7_ALT) ? 5'd1 : 5'd0;
          3'b001:  addr_d = 5'd5;
          3'b010:  addr_d = 5'd6;
          3'b011:  addr_d = 5'd7;
          3'b100:  addr_d = 5'd2;
          3'b101:  addr_d = 5'd5;
          3'b110:  addr_d = 5'd3;
          default: addr_d = 5'd4;
        endcase
        if (funct3 == 3'b101) shift_d = w[30] ? 2'b10 : 2'b01;
      end
      OP_IMM: begin
        legal_d = 1'b1;
        imm_d   = imm_i;
        case (funct3)
          3'b000:  addr_d = 5'd8;
          3'b010:  addr_d = 5'd13;
          3'b011:  addr_d = 5'd14;
          3'b100:  addr_d = 5'd9;
          3'b110:  addr_d = 5'd10;
          3'b111:  addr_d = 5'd11;
          default: begin
            // Shift-immediates carry a zero-extended shamt, not a signed constant.
            addr_d  = 5'd12;
            imm_d   = imm_sh;
            legal_d = (funct7 == 7'b0) || (funct3 == 3'b101 && funct7 == F7_ALT);
          end
        endcase
        if (funct3 == 3'b101) shift_d = w[30] ? 2'b10 : 2'b01;
      end
      OP_LOAD: begin
        legal_d = (funct3 == 3'b010);
        addr_d  = 5'd15;
        imm_d   = imm_i;
      end
      OP_STORE: begin
        legal_d = (funct3 == 3'b010);
        addr_d  = 5'd16;
        imm_d   = imm_s;
      end
      OP_LUI: begin
        legal_d = 1'b1;
        addr_d  = 5'd17;
        imm_d   = imm_u;
      end
      OP_AUIPC: begin
        legal_d = 1'b1;
        addr_d  = 5'd18;
        imm_d   = imm_u;
      end
      OP_JAL: begin
        legal_d = 1'b1;
        addr_d  = 5'd19;
        imm_d   = imm_j;
      end
      OP_JALR: begin
        legal_d = (funct3 == 3'b000);
        addr_d  = 5'd20;
        imm_d   = imm_i;
      end
      OP_BRANCH: begin
        legal_d = (funct3 != 3'b010) && (funct3 != 3'b011);
        addr_d  = 5'd21;
        imm_d   = imm_b;
      end
      default: legal_d = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_id_valid_inst) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      // The issue pulse flop doubles as the registered legality of the held word.
      ST_ISSUE: state_d = valid_q ? ST_WAIT : ST_IDLE;
      ST_WAIT:  if (done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: only control and output flops exist here; all of them reset, so an
    // abort mid-instruction leaves no stale pulse behind.
    if (!rst) begin
      state_q       <= ST_IDLE;
      decode_addr_q <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      immediate_q   <= '0;
      pc_q          <= '0;
      pc_plus4_q    <= COLS'(4);
      shift_q       <= '0;
      valid_q       <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= accept && legal_d;
      illegal_q <= accept && !legal_d;
      if (accept) begin
        decode_addr_q <= addr_d;
        rd_q          <= w[11:7];
        rs1_q         <= w[19:15];
        rs2_q         <= w[24:20];
        immediate_q   <= COLS'(imm_d);
        pc_q          <= if_id_pc;
        pc_plus4_q    <= if_id_pc + COLS'(4);
        shift_q       <= shift_d;
      end
    end
  end

  assign id_ready             = (state_q == ST_IDLE);
  assign decode_addr          = decode_addr_q;
  assign id_rf_valid_inst     = valid_q;
  assign illegal_inst         = illegal_q;
  assign rd_index             = rd_q;
  assign rs1_index            = rs1_q;
  assign rs2_index            = rs2_q;
  assign immediate            = immediate_q;
  assign pc_reg               = pc_q;
  assign pc_plus4             = pc_plus4_q;
  assign id_rf_shift_controls = shift_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: transaction-level decode model checked every cycle, plus
// directed instructions with hand-derived field values.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        done = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;

  logic        id_ready, id_rf_valid_inst, illegal_inst;
  logic [4:0]  decode_addr, rd_index, rs1_index, rs2_index;
  logic [31:0] immediate, pc_reg, pc_plus4;
  logic [1:0]  shift_ctl;

  id_stage #(.COLS(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .if_id_valid_inst     (valid),
    .if_id_instr          (instr),
    .if_id_pc             (pc),
    .id_ready             (id_ready),
    .done                 (done),
    .decode_addr          (decode_addr),
    .id_rf_valid_inst     (id_rf_valid_inst),
    .rd_index             (rd_index),
    .rs1_index            (rs1_index),
    .rs2_index            (rs2_index),
    .immediate            (immediate),
    .pc_reg               (pc_reg),
    .pc_plus4             (pc_plus4),
    .id_rf_shift_controls (shift_ctl),
    .illegal_inst         (illegal_inst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit        legal;
    bit [4:0]  addr;
    bit        has_imm;
    bit [31:0] imm;
    bit [1:0]  shift;
  } dec_t;

  function automatic dec_t decode(input bit [31:0] x);
    dec_t r;
    int   r_tab[8] = '{0, 5, 6, 7, 2, 5, 3, 4};
    int   i_tab[8] = '{8, 12, 13, 14, 9, 12, 10, 11};
    bit [6:0] op = x[6:0];
    bit [2:0] f3 = x[14:12];
    bit [6:0] f7 = x[31:25];
    int sx = x[31] ? -1 : 0;
    bit is_shift = (f3 == 3'd1) || (f3 == 3'd5);
    r.legal = 0; r.addr = 0; r.has_imm = 1; r.imm = 0; r.shift = 0;
    case (op)
      7'b0110011: begin
        r.has_imm = 0;
        r.legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        r.addr  = (f3 == 0 && f7 == 7'h20) ? 5'd1 : 5'(r_tab[f3]);
        if (f3 == 5) r.shift = x[30] ? 2 : 1;
      end
      7'b0010011: begin
        r.legal = !is_shift || f7 == 0 || (f3 == 5 && f7 == 7'h20);
        r.addr  = 5'(i_tab[f3]);
        r.imm   = is_shift ? 32'(int'(x[24:20])) : 32'(sx * 2048 + int'(x[30:20]));
        if (f3 == 5) r.shift = x[30] ? 2 : 1;
      end
      7'b0000011: begin r.legal = (f3 == 2); r.addr = 15; r.imm = 32'(sx * 2048 + int'(x[30:20])); end
      7'b0100011: begin
        r.legal = (f3 == 2); r.addr = 16;
        r.imm = 32'(sx * 2048 + int'(x[30:25]) * 32 + int'(x[11:7]));
      end
      7'b0110111: begin r.legal = 1; r.addr = 17; r.imm = x & 32'hFFFF_F000; end
      7'b0010111: begin r.legal = 1; r.addr = 18; r.imm = x & 32'hFFFF_F000; end
      7'b1101111: begin
        r.legal = 1; r.addr = 19;
        r.imm = 32'(sx * 1048576 + int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2);
      end
      7'b1100111: begin r.legal = (f3 == 0); r.addr = 20; r.imm = 32'(sx * 2048 + int'(x[30:20])); end
      7'b1100011: begin
        r.legal = (f3 != 2) && (f3 != 3); r.addr = 21;
        r.imm = 32'(sx * 4096 + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2);
      end
      default: r.legal = 0;
    endcase
    return r;
  endfunction

  // Model: phase 0 = free, 1 = cycle after accept, 2 = outstanding until done.
  int        m_phase = 0;
  bit        m_valid = 0, m_illegal = 0, m_legal = 1, m_imm_ok = 1;
  bit [4:0]  m_addr = 0, m_rd = 0, m_rs1 = 0, m_rs2 = 0;
  bit [31:0] m_imm = 0, m_pc = 0, m_pc4 = 4;
  bit [1:0]  m_shift = 0;
  dec_t      m_dec;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_valid = 0; m_illegal = 0; m_legal = 1; m_imm_ok = 1;
      m_addr = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
      m_imm = 0; m_pc = 0; m_pc4 = 4; m_shift = 0;
    end else begin
      m_valid = 0;
      m_illegal = 0;
      if (m_phase == 0 && valid) begin
        m_dec     = decode(instr);
        m_phase   = 1;
        m_legal   = m_dec.legal;
        m_valid   = m_dec.legal;
        m_illegal = !m_dec.legal;
        m_imm_ok  = m_dec.legal && m_dec.has_imm;
        m_addr    = m_dec.addr;
        m_imm     = m_dec.imm;
        m_shift   = m_dec.shift;
        m_rd      = instr[11:7];
        m_rs1     = instr[19:15];
        m_rs2     = instr[24:20];
        m_pc      = pc;
        m_pc4     = pc + 32'd4;
      end else if (m_phase == 1) begin
        m_phase = m_legal ? 2 : 0;
      end else if (m_phase == 2 && done) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("ready", id_ready, m_phase == 0);
    check("valid_pulse", id_rf_valid_inst, m_valid);
    check("illegal_pulse", illegal_inst, m_illegal);
    check("rd", rd_index, m_rd);
    check("rs1", rs1_index, m_rs1);
    check("rs2", rs2_index, m_rs2);
    check("pc_reg", pc_reg, m_pc);
    check("pc_plus4", pc_plus4, m_pc4);
    if (m_legal) begin
      check("decode_addr", decode_addr, m_addr);
      check("shift", shift_ctl, m_shift);
    end
    if (m_imm_ok) check("immediate", immediate, m_imm);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Presents a word and returns in the cycle after the accepting edge.
  task automatic send(input logic [31:0] x, input logic [31:0] p, input bit keep_valid = 0);
    bit got = 0;
    instr = x;
    pc    = p;
    valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (id_ready) begin
        got = 1;
        step();
        break;
      end
      step();
    end
    if (!keep_valid) valid = 1'b0;
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic finish_inst(input int wait_cycles);
    repeat (wait_cycles) step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("ready_after_done", id_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    check("rst_ready", id_ready, 1);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_addr", decode_addr, 0);
    check("rst_valid", id_rf_valid_inst, 0);
    rst = 1'b1;
    step();

    // ADD x3,x1,x2
    send(32'h002081B3, 32'h100);
    check("add_valid", id_rf_valid_inst, 1);
    check("add_addr", decode_addr, 0);
    check("add_rd", rd_index, 3);
    check("add_rs1", rs1_index, 1);
    check("add_rs2", rs2_index, 2);
    check("add_pc", pc_reg, 32'h100);
    check("add_pc4", pc_plus4, 32'h104);
    check("add_ready_low", id_ready, 0);
    step();
    check("add_single_pulse", id_rf_valid_inst, 0);
    check("add_wait_ready", id_ready, 0);
    finish_inst(2);

    // SRAI / SRLI x5,x6,7
    send(32'h40735293, 32'h104);
    check("srai_addr", decode_addr, 12);
    check("srai_imm", immediate, 7);
    check("srai_shift", shift_ctl, 2'b10);
    finish_inst(1);
    send(32'h00735293, 32'h108);
    check("srli_addr", decode_addr, 12);
    check("srli_shift", shift_ctl, 2'b01);
    finish_inst(1);

    // Signed immediates
    send(32'hFE20AE23, 32'h10C);
    check("sw_addr", decode_addr, 16);
    check("sw_imm", immediate, 32'hFFFF_FFFC);
    finish_inst(1);
    send(32'hFF9FF0EF, 32'h110);
    check("jal_addr", decode_addr, 19);
    check("jal_imm", immediate, 32'hFFFF_FFF8);
    finish_inst(1);
    send(32'hABCDE3B7, 32'h114);
    check("lui_addr", decode_addr, 17);
    check("lui_imm", immediate, 32'hABCD_E000);
    finish_inst(1);

    // Illegal encodings: bad opcode, bad R funct7, SLLI with alt funct7
    send(32'h0000007F, 32'h200);
    check("ill_pulse", illegal_inst, 1);
    check("ill_no_valid", id_rf_valid_inst, 0);
    step();
    check("ill_pulse_end", illegal_inst, 0);
    check("ill_ready_back", id_ready, 1);
    send(32'h022081B3, 32'h204);
    check("ill_funct7", illegal_inst, 1);
    step();
    send(32'h40731293, 32'h208);
    check("ill_slli_alt", illegal_inst, 1);
    step();

    // Valid held through WAIT with a different word presented
    send(32'hFFF00093, 32'h300, 1);
    instr = 32'h002081B3;
    pc    = 32'h400;
    check("hold_addr", decode_addr, 8);
    repeat (10) step();
    check("hold_addr_stable", decode_addr, 8);
    check("hold_imm_stable", immediate, 32'hFFFF_FFFF);
    check("hold_pc_stable", pc_reg, 32'h300);
    finish_inst(0);
    send(32'h002081B3, 32'h400);
    check("held_next_pc", pc_reg, 32'h400);
    finish_inst(1);

    // done during the issue cycle is ignored
    send(32'h402081B3, 32'h500);
    check("sub_addr", decode_addr, 1);
    done = 1'b1;
    step();
    done = 1'b0;
    check("done_in_issue_ignored", id_ready, 0);
    finish_inst(1);

    // Branches: BGE with instr[30] set keeps shift 00; BEQ at wrap PC
    send(32'h40005063, 32'h600);
    check("bge_addr", decode_addr, 21);
    check("bge_imm", immediate, 32'h400);
    check("bge_shift", shift_ctl, 0);
    finish_inst(1);
    send(32'h00000063, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 0);
    finish_inst(1);

    // Reset while waiting for done
    send(32'h00001117, 32'h700);
    check("auipc_addr", decode_addr, 18);
    check("auipc_imm", immediate, 32'h1000);
    step();
    #1 rst = 1'b0;
    #1;
    check("abort_ready", id_ready, 1);
    check("abort_addr", decode_addr, 0);
    check("abort_imm", immediate, 0);
    check("abort_pc4", pc_plus4, 32'h4);
    check("abort_rd", rd_index, 0);
    step();
    rst = 1'b1;
    step();
    check("abort_no_pulse", id_rf_valid_inst, 0);
    send(32'h004100E7, 32'h800);
    check("jalr_valid", id_rf_valid_inst, 1);
    check("jalr_addr", decode_addr, 20);
    check("jalr_imm", immediate, 4);
    check("jalr_rs1", rs1_index, 2);
    finish_inst(1);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
